aes_enc_arbiter: RTL

AES_ENC_ARBITER -- requirements
Module: aes_enc_arbiter

---
 rtl/aes_enc_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/aes_enc_arbiter.sv
// aes_enc_arbiter
//   Shares one AES encrypt core between two requesters. Only one job is in
//   flight at a time. A fair round-robin grant is made in IDLE, the operands
//   are captured, the core is started with a one-cycle pulse, and the core
//   is watched for completion or timeout. The result is then held until the
//   consumer accepts it.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   reqN_valid / reqN_ready   job handshake for requester N (0,1)
//   reqN_pt / reqN_key        128-bit plaintext / key for requester N
//   rsp_valid / rsp_ready     result handshake
//   rsp_id                    requester that owns the result
//   rsp_data                  ciphertext (zero when rsp_err is set)
//   rsp_err                   core did not finish within TIMEOUT cycles
//   core_start                one-cycle start pulse to the core
//   core_pt / core_key        operands to the core, stable for the whole job
//   core_ct / core_done       core result and completion pulse
module aes_enc_arbiter #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [127:0] req0_pt,
  input  logic [127:0] req1_pt,
  input  logic [127:0] req0_key,
  input  logic [127:0] req1_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         core_start,
  output logic [127:0] core_pt,
  output logic [127:0] core_key,
  input  logic [127:0] core_ct,
  input  logic         core_done
);

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_e;

  localparam logic [4:0] TMO = 5'(TIMEOUT);

  state_e             state_q;
  logic               last_q;      // requester served most recently
  logic               id_q;
  logic [127:0]       pt_q, key_q, data_q;
  logic               err_q;
  logic               start_q, valid_q;
  logic [4:0]         timer_q, timer_d;

  logic [1:0]         req_vld;
  logic [1:0][127:0]  req_pt, req_key;
  logic               gnt_id, acc;

  assign req_vld = {req1_valid, req0_valid};
  assign req_pt  = {req1_pt,  req0_pt};
  assign req_key = {req1_key, req0_key};

  // Tie goes to whoever was not served last; otherwise the lone requester.
  assign gnt_id = (&req_vld) ? ~last_q : req_vld[1];
  assign acc    = (state_q == IDLE) && !rst && (|req_vld);

  // Ready is gated by rst so outputs stay quiet while reset is held.
  assign req0_ready = acc && req0_valid && !gnt_id;
  assign req1_ready = acc && req1_valid &&  gnt_id;

  // Timeout fires on the BUSY cycle whose incremented count reaches TIMEOUT,
  // which puts rsp_valid exactly TIMEOUT+1 cycles after core_start.
  assign timer_d = timer_q + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      pt_q    <= '0;
      key_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            pt_q    <= req_pt[gnt_id];
            key_q   <= req_key[gnt_id];
            id_q    <= gnt_id;
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          start_q <= 1'b0;
          timer_q <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          if (core_done) begin
            // done wins over a coincident timeout
            data_q  <= core_ct;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= RESP;
          end else begin
            timer_q <= timer_d;
            if (timer_d == TMO) begin
              data_q  <= '0;
              err_q   <= 1'b1;
              valid_q <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
            last_q  <= id_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = valid_q;
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;
  assign core_start = start_q;
  assign core_pt    = pt_q;
  assign core_key   = key_q;

endmodule
